// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the byte-enable dual-port RAM:
//   - read-during-write mode selectors
//   - clear-engine state encoding
//   - be_merge: byte-lane merge of a new word into an old word
// No ports (package).
// ---------------------------------------------------------------------------
package bram_pkg;

    localparam int unsigned RDW_WRITE_FIRST = 0;
    localparam int unsigned RDW_READ_FIRST  = 1;
    localparam int unsigned RDW_NO_CHANGE   = 2;

    // be_merge works on a fixed maximum width; callers cast in and out.
    localparam int unsigned MERGE_W = 256;
    localparam int unsigned MERGE_B = MERGE_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    // Replace each byte of old_w whose mask bit is set with the byte of new_w.
    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_B-1:0] mask
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < MERGE_B; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_dp_be_if.sv
// ---------------------------------------------------------------------------
// bram_dp_be_if
// Bus bundle for both RAM ports plus the status outputs.
//   a_/b_ en, wr, be, addr, din : requests (master -> slave)
//   a_/b_ dout, valid           : read return (slave -> master)
//   busy, collision             : status (slave -> master)
// ---------------------------------------------------------------------------
interface bram_dp_be_if #(
    parameter int unsigned DATA = 32,
    parameter int unsigned ADDR = 7
);
    localparam int unsigned BE_W = DATA / 8;

    logic            a_en;
    logic            a_wr;
    logic [BE_W-1:0] a_be;
    logic [ADDR-1:0] a_addr;
    logic [DATA-1:0] a_din;
    logic [DATA-1:0] a_dout;
    logic            a_valid;

    logic            b_en;
    logic            b_wr;
    logic [BE_W-1:0] b_be;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_din;
    logic [DATA-1:0] b_dout;
    logic            b_valid;

    logic            busy;
    logic            collision;

    modport master (
        output a_en, a_wr, a_be, a_addr, a_din,
        output b_en, b_wr, b_be, b_addr, b_din,
        input  a_dout, a_valid, b_dout, b_valid, busy, collision
    );

    modport slave (
        input  a_en, a_wr, a_be, a_addr, a_din,
        input  b_en, b_wr, b_be, b_addr, b_din,
        output a_dout, a_valid, b_dout, b_valid, busy, collision
    );

endinterface

// File: rtl/bram_rd_pipe.sv
// ---------------------------------------------------------------------------
// bram_rd_pipe
// Read-return stage for one RAM port: a mandatory capture register and an
// optional second register (OUT_REG=1). Data holds between accesses.
//   clk, rst : clock, synchronous active-high reset
//   i_fire   : an access completes this cycle
//   i_data   : word to return for that access
//   o_dout   : returned word
//   o_valid  : one-cycle strobe, o_dout updated
// ---------------------------------------------------------------------------
module bram_rd_pipe #(
    parameter int unsigned DATA    = 32,
    parameter int unsigned OUT_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_fire,
    input  logic [DATA-1:0] i_data,
    output logic [DATA-1:0] o_dout,
    output logic            o_valid
);

    logic [DATA-1:0] r_d1;
    logic            r_v1;

    // First stage: capture on every completed access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= i_fire;
            if (i_fire) begin
                r_d1 <= i_data;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA-1:0] r_d2;
        logic            r_v2;

        // Second stage only loads on a first-stage strobe so dout holds.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_d2 <= '0;
                r_v2 <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= r_d1;
                end
            end
        end

        assign o_dout  = r_d2;
        assign o_valid = r_v2;
    end else begin : g_no_out_reg
        assign o_dout  = r_d1;
        assign o_valid = r_v1;
    end

endmodule

// File: rtl/bram_dp_be.sv
// ---------------------------------------------------------------------------
// bram_dp_be
// Single-clock true dual-port RAM with byte enables, selectable same-port
// read-during-write behaviour, optional output register, write-write
// collision merge/flag, and a post-reset clear engine.
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : bram_dp_be_if slave (both ports' requests/returns,
//               busy, collision)
// ---------------------------------------------------------------------------
module bram_dp_be
    import bram_pkg::*;
#(
    parameter int unsigned    DATA         = 32,
    parameter int unsigned    ADDR         = 7,
    parameter int unsigned    RDW_MODE     = 0,
    parameter int unsigned    OUT_REG      = 0,
    parameter int unsigned    CLEAR_ON_RST = 1,
    parameter logic [DATA-1:0] CLEAR_VAL   = '0
) (
    input  logic         clk,
    input  logic         rst,
    bram_dp_be_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR;

    if ((DATA % 8) != 0 || DATA == 0 || DATA > MERGE_W) begin : g_bad_data
        $error("bram_dp_be: DATA must be a nonzero multiple of 8, at most %0d", MERGE_W);
    end

    logic [DATA-1:0] r_mem [DEPTH];

    clr_state_e      r_state;
    logic [ADDR-1:0] r_cnt;
    logic            r_busy;
    logic            r_coll;

    logic            w_a_acc, w_b_acc;
    logic            w_a_wr, w_b_wr;
    logic            w_ww;
    logic [DATA-1:0] w_a_old, w_b_old;
    logic [DATA-1:0] w_a_new, w_b_new;
    logic            w_a_fire, w_b_fire;
    logic [DATA-1:0] w_a_rd, w_b_rd;

    assign w_a_acc = bus.a_en & ~r_busy;
    assign w_b_acc = bus.b_en & ~r_busy;
    assign w_a_wr  = w_a_acc & bus.a_wr;
    assign w_b_wr  = w_b_acc & bus.b_wr;
    assign w_ww    = w_a_wr & w_b_wr & (bus.a_addr == bus.b_addr);

    assign w_a_old = r_mem[bus.a_addr];
    assign w_b_old = r_mem[bus.b_addr];

    // On a same-address write-write, A is layered over B's merge so
    // shared bytes take A's data.
    always_comb begin
        w_b_new = DATA'(be_merge(MERGE_W'(w_b_old), MERGE_W'(bus.b_din), MERGE_B'(bus.b_be)));
        w_a_new = DATA'(be_merge(MERGE_W'(w_ww ? w_b_new : w_a_old),
                                 MERGE_W'(bus.a_din), MERGE_B'(bus.a_be)));
    end

    // Read-return selection per port.
    always_comb begin
        w_a_fire = w_a_acc;
        w_a_rd   = w_a_old;
        w_b_fire = w_b_acc;
        w_b_rd   = w_b_old;
        if (w_a_wr) begin
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                w_a_rd = w_a_new;
            end else if (RDW_MODE == RDW_NO_CHANGE) begin
                w_a_fire = 1'b0;
            end
        end
        if (w_b_wr) begin
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                w_b_rd = w_ww ? w_a_new : w_b_new;
            end else if (RDW_MODE == RDW_NO_CHANGE) begin
                w_b_fire = 1'b0;
            end
        end
    end

    // Memory array: clear engine or port writes, never during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_busy) begin
                r_mem[r_cnt] <= CLEAR_VAL;
            end else begin
                if (w_a_wr) begin
                    r_mem[bus.a_addr] <= w_a_new;
                end
                if (w_b_wr && !w_ww) begin
                    r_mem[bus.b_addr] <= w_b_new;
                end
            end
        end
    end

    // Clear FSM; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            if (CLEAR_ON_RST != 0) begin
                r_state <= ST_CLEAR;
                r_busy  <= 1'b1;
            end else begin
                r_state <= ST_READY;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + ADDR'(1);
                    if (r_cnt == ADDR'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Collision flag only when the overlapping writes share a byte lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_ww & (|(bus.a_be & bus.b_be));
        end
    end

    assign bus.busy      = r_busy;
    assign bus.collision = r_coll;

    bram_rd_pipe #(.DATA(DATA), .OUT_REG(OUT_REG)) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .i_fire  (w_a_fire),
        .i_data  (w_a_rd),
        .o_dout  (bus.a_dout),
        .o_valid (bus.a_valid)
    );

    bram_rd_pipe #(.DATA(DATA), .OUT_REG(OUT_REG)) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .i_fire  (w_b_fire),
        .i_data  (w_b_rd),
        .o_dout  (bus.b_dout),
        .o_valid (bus.b_valid)
    );

endmodule

// File: tb/tb_bram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_bram_dp_be
// Three RAM instances (ADDR=4, CLEAR_VAL=DEADBEEF) share one stimulus:
//   dut0: write-first, dut1: read-first + output register, dut2: no-change.
// A behavioural word-array model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_bram_dp_be;

    localparam logic [31:0] CLR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_wr, b_en, b_wr;
    logic [3:0]  a_be, b_be, a_addr, b_addr;
    logic [31:0] a_din, b_din;

    logic [31:0] d_dout  [3][2];
    logic        d_valid [3][2];
    logic        d_busy  [3];
    logic        d_coll  [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        bram_dp_be_if #(.DATA(32), .ADDR(4)) bus ();

        assign bus.a_en   = a_en;
        assign bus.a_wr   = a_wr;
        assign bus.a_be   = a_be;
        assign bus.a_addr = a_addr;
        assign bus.a_din  = a_din;
        assign bus.b_en   = b_en;
        assign bus.b_wr   = b_wr;
        assign bus.b_be   = b_be;
        assign bus.b_addr = b_addr;
        assign bus.b_din  = b_din;

        assign d_dout[k][0]  = bus.a_dout;
        assign d_valid[k][0] = bus.a_valid;
        assign d_dout[k][1]  = bus.b_dout;
        assign d_valid[k][1] = bus.b_valid;
        assign d_busy[k]     = bus.busy;
        assign d_coll[k]     = bus.collision;

        bram_dp_be #(
            .DATA         (32),
            .ADDR         (4),
            .RDW_MODE     (k),
            .OUT_REG      ((k == 1) ? 1 : 0),
            .CLEAR_ON_RST (1),
            .CLEAR_VAL    (CLR)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [16];
    int          clr_left = 0;
    bit          m_live = 0;
    logic [31:0] e_dout  [3][2];
    bit          e_valid [3][2];
    bit          p_v     [3][2];
    logic [31:0] p_d     [3][2];
    bit          e_busy, e_coll;

    always @(posedge clk) begin
        logic [31:0] snap [16];
        bit          busy_now, fire, ov;
        logic [31:0] res, od;
        bit          en [2];
        bit          wr [2];
        logic [3:0]  ad [2];
        en[0] = a_en; wr[0] = a_wr; ad[0] = a_addr;
        en[1] = b_en; wr[1] = b_wr; ad[1] = b_addr;
        if (rst) begin
            m_live   = 1;
            clr_left = 16;
            e_busy   = 1;
            e_coll   = 0;
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 2; p++) begin
                    e_dout[k][p] = '0; e_valid[k][p] = 0;
                    p_v[k][p] = 0;     p_d[k][p] = '0;
                end
        end else begin
            busy_now = (clr_left > 0);
            snap     = m_mem;
            e_coll   = 0;
            if (busy_now) begin
                m_mem[16 - clr_left] = CLR;
                clr_left--;
            end else begin
                if (b_en && b_wr)
                    for (int i = 0; i < 4; i++)
                        if (b_be[i]) m_mem[b_addr][8*i +: 8] = b_din[8*i +: 8];
                if (a_en && a_wr)
                    for (int i = 0; i < 4; i++)
                        if (a_be[i]) m_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
                e_coll = a_en && a_wr && b_en && b_wr && (a_addr == b_addr) && ((a_be & b_be) != 0);
            end
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 2; p++) begin
                    fire = 0; res = '0;
                    if (!busy_now && en[p]) begin
                        if (!wr[p])      begin fire = 1; res = snap[ad[p]];  end
                        else if (k == 0) begin fire = 1; res = m_mem[ad[p]]; end
                        else if (k == 1) begin fire = 1; res = snap[ad[p]];  end
                    end
                    if (k == 1) begin
                        ov = p_v[k][p]; od = p_d[k][p];
                        p_v[k][p] = fire; p_d[k][p] = res;
                    end else begin
                        ov = fire; od = res;
                    end
                    e_valid[k][p] = ov;
                    if (ov) e_dout[k][p] = od;
                end
            e_busy = (clr_left > 0);
        end
    end

    // Compare every output of every instance each cycle.
    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 3; k++) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("dut%0d port%0d valid", k, p), 32'(d_valid[k][p]), 32'(e_valid[k][p]));
                    chk($sformatf("dut%0d port%0d dout", k, p), d_dout[k][p], e_dout[k][p]);
                end
                chk($sformatf("dut%0d busy", k), 32'(d_busy[k]), 32'(e_busy));
                chk($sformatf("dut%0d collision", k), 32'(d_coll[k]), 32'(e_coll));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv_a(input logic en, input logic wr, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] din);
        a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic drv_b(input logic en, input logic wr, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] din);
        b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
    endtask

    task automatic idle();
        drv_a(0, 0, 4'h0, 4'h0, 32'h0);
        drv_b(0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (d_busy[0] && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_busy("busy_len");

        // Every word reads back as the clear value.
        for (int i = 0; i < 16; i++) begin
            drv_a(1, 0, 4'h0, 4'(i), 32'h0);
            @(negedge clk);
            chk("clear_read", d_dout[0][0], CLR);
        end
        idle();
        repeat (3) @(negedge clk);

        // Reset mid-clear restarts the full clear.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy("busy_len_restart");

        // Byte enables.
        drv_a(1, 1, 4'b1111, 4'd3, 32'h11223344);
        @(negedge clk);
        drv_a(1, 1, 4'b0101, 4'd3, 32'hAABBCCDD);
        @(negedge clk);
        idle();
        drv_b(1, 0, 4'h0, 4'd3, 32'h0);
        @(negedge clk);
        chk("be_merge", d_dout[0][1], 32'h11BB33DD);
        idle();

        // Read-during-write at addr 7 (A's last returned word: addr 3).
        drv_a(1, 1, 4'b1111, 4'd7, 32'h0);
        @(negedge clk);
        drv_a(1, 0, 4'h0, 4'd3, 32'h0);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        drv_a(1, 1, 4'b1111, 4'd7, 32'h5);
        drv_b(1, 0, 4'h0, 4'd7, 32'h0);
        @(negedge clk);
        chk("rdw_wf_dout", d_dout[0][0], 32'h5);
        chk("rdw_wf_valid", 32'(d_valid[0][0]), 32'd1);
        chk("rdw_nc_valid", 32'(d_valid[2][0]), 32'd0);
        chk("rdw_nc_dout", d_dout[2][0], 32'h11BB33DD);
        chk("rdw_cross_b", d_dout[0][1], 32'h0);
        idle();
        @(negedge clk);
        chk("rdw_rf_dout", d_dout[1][0], 32'h0);
        chk("rdw_rf_valid", 32'(d_valid[1][0]), 32'd1);
        chk("rdw_rf_cross_b", d_dout[1][1], 32'h0);

        // Write-write collision at addr 9.
        drv_a(1, 1, 4'b1111, 4'd9, 32'h0);
        @(negedge clk);
        drv_a(1, 1, 4'b0011, 4'd9, 32'hAAAAAAAA);
        drv_b(1, 1, 4'b0110, 4'd9, 32'hBBBBBBBB);
        @(negedge clk);
        chk("coll_pulse", 32'(d_coll[0]), 32'd1);
        idle();
        drv_a(1, 0, 4'h0, 4'd9, 32'h0);
        @(negedge clk);
        chk("coll_single", 32'(d_coll[0]), 32'd0);
        chk("coll_word", d_dout[0][0], 32'h00BBAAAA);
        drv_a(1, 1, 4'b0011, 4'd9, 32'hAAAAAAAA);
        drv_b(1, 1, 4'b1100, 4'd9, 32'hBBBBBBBB);
        @(negedge clk);
        chk("coll_disjoint", 32'(d_coll[0]), 32'd0);
        idle();

        // Streaming reads through the output register (dut1).
        for (int i = 0; i < 3; i++) begin
            drv_a(1, 1, 4'b1111, 4'(i), 32'h100 + 32'(i));
            @(negedge clk);
        end
        idle();
        repeat (3) @(negedge clk);
        drv_a(1, 0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        chk("strm_lat", 32'(d_valid[1][0]), 32'd0);
        drv_a(1, 0, 4'h0, 4'd1, 32'h0);
        @(negedge clk);
        chk("strm_v0", 32'(d_valid[1][0]), 32'd1);
        chk("strm_d0", d_dout[1][0], 32'h100);
        drv_a(1, 0, 4'h0, 4'd2, 32'h0);
        @(negedge clk);
        chk("strm_v1", 32'(d_valid[1][0]), 32'd1);
        chk("strm_d1", d_dout[1][0], 32'h101);
        idle();
        @(negedge clk);
        chk("strm_v2", 32'(d_valid[1][0]), 32'd1);
        chk("strm_d2", d_dout[1][0], 32'h102);
        @(negedge clk);
        chk("strm_end_v", 32'(d_valid[1][0]), 32'd0);
        chk("strm_hold", d_dout[1][0], 32'h102);

        // Random traffic, biased toward two addresses to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 249) == 0);
            a_en   = ($urandom_range(0, 3) != 0);
            a_wr   = 1'($urandom_range(0, 1));
            a_be   = 4'($urandom);
            a_addr = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(8, 9)) : 4'($urandom);
            a_din  = $urandom;
            b_en   = ($urandom_range(0, 3) != 0);
            b_wr   = 1'($urandom_range(0, 1));
            b_be   = 4'($urandom);
            b_addr = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(8, 9)) : 4'($urandom);
            b_din  = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        idle();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
- Single-clock, true dual-port block RAM for the SPI flash controller's page buffers and command queues.
- Generalises the existing dual-port RAM with:
  - per-byte write enables
  - a selectable same-port read-during-write mode
  - an optional output register with a read-valid strobe
  - a defined write-write collision policy
  - a sequential memory-clear engine run after reset

Parameters:
- DATA, 32: word width in bits. Must be a multiple of 8; any other value is an elaboration error.
- ADDR, 7: address width; depth is 2**ADDR words.
- RDW_MODE, 0: same-port read-during-write. 0 = write-first, 1 = read-first, 2 = no-change.
- OUT_REG, 0: 1 adds an output pipeline register, giving read latency 2.
- CLEAR_ON_RST, 1: 1 clears every word to CLEAR_VAL after reset.
- CLEAR_VAL, 0: DATA-bit fill value used by the clear engine.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- a_en  in  1  port A access request
- a_wr  in  1  port A write (qualified by a_en)
- a_be  in  DATA/8  port A byte enables; bit i covers din[8i+7:8i]
- a_addr  in  ADDR  port A word address
- a_din  in  DATA  port A write data
- a_dout  out  DATA  port A read data
- a_valid  out  1  a_dout updated this cycle
- b_en, b_wr, b_be, b_addr, b_din, b_dout, b_valid: same as port A, for port B
- busy  out  1  clear engine active; all requests ignored
- collision  out  1  one-cycle pulse on a same-address write-write collision

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high.
  - While rst=1: a_dout=b_dout=0, a_valid=b_valid=0, collision=0.
  - busy=1 if CLEAR_ON_RST, else 0.
  - Memory contents are not touched while rst=1.
- Clear FSM states: CLEAR and READY.
  - rst forces CLEAR with cnt=0 when CLEAR_ON_RST=1, otherwise READY.
  - In CLEAR, one word is written per cycle: mem[cnt]<=CLEAR_VAL, cnt++.
  - After writing word 2**ADDR-1, go to READY. busy drops on the following cycle, so busy is high for exactly 2**ADDR cycles after rst falls.
  - rst asserted mid-clear restarts the clear at cnt=0.
- While busy=1:
  - Port requests are dropped: no memory write, no valid, douts hold their value.
  - Nothing is queued.
- Access accepted: an access is accepted when en=1 and busy=0.
  - Write: only bytes with be=1 are updated; be=0 with wr=1 is a legal no-op write.
  - Every accepted access (read or write) produces a dout update and a valid pulse.
- Latency: dout and valid appear 1 cycle after acceptance (OUT_REG=0) or 2 cycles (OUT_REG=1).
  - Valid is a single-cycle pulse per access; back-to-back accesses give back-to-back pulses.
  - dout holds its value between accesses.
  - With OUT_REG=1, rst also clears the pipeline stage.
- Same-port write, returned dout:
  - write-first: the post-write word (merged bytes).
  - read-first: the pre-write word.
  - no-change: dout is not updated and no valid pulse is generated.
- Cross-port read vs write, same address, same cycle: the reader returns the pre-write word.
- Write-write collision (both ports write the same address in the same cycle):
  - Bytes enabled on both ports take port A's data; bytes enabled on one port only take that port's data.
  - collision pulses one cycle later (aligned with 1-cycle latency, independent of OUT_REG) whenever the be masks overlap.
- Address wrap: none; every address is in range by construction.

Decomposition:
- Package bram_pkg:
  - RDW_WRITE_FIRST/RDW_READ_FIRST/RDW_NO_CHANGE constants
  - clear FSM state encoding (ST_CLEAR, ST_READY)
  - be_merge function (old word, new word, mask)
- Sub-module bram_rd_pipe, instantiated once per port:
  - optional output register plus valid delay, selected by OUT_REG
  - carries its own synchronous rst
- Top level holds the memory array, collision/merge logic and clear FSM.

Test Plan:
- Clear after reset (ADDR=4, CLEAR_VAL=32'hDEADBEEF):
  - Stimulus: rst 3 cycles; then read addr 0..15 on A.
  - Response: busy high exactly 16 cycles after rst falls; every read returns DEADBEEF; no valid while busy.
  - Reset mid-clear: rst pulsed at cnt=5 restarts the clear; busy then lasts a full 16 cycles.
- Byte enables:
  - A writes 32'h11223344 to addr 3 with be=4'b1111, then 32'hAABBCCDD with be=4'b0101.
  - B reads addr 3 and gets 32'h11BB33DD.
- Read-during-write, addr 7 holds 32'h0, A writes 32'h5 to addr 7:
  - RDW_MODE=0: a_dout=5, one valid.
  - RDW_MODE=1: a_dout=0, one valid.
  - RDW_MODE=2: no valid, a_dout unchanged.
  - Same cycle B reads addr 7: b_dout=0.
- Write-write collision at addr 9:
  - A writes 32'hAAAAAAAA with be=4'b0011; B writes 32'hBBBBBBBB with be=4'b0110.
  - Memory becomes 32'h00BBAAAA (prior 0); collision pulses one cycle.
  - Repeat with disjoint masks: no pulse.
- OUT_REG=1 streaming:
  - A reads addr 0,1,2 on consecutive cycles.
  - a_valid high on cycles 2,3,4 relative to the first request, with matching data; dout holds after the last pulse.
